// File: rtl/des_ks_if.sv
// Bundle of key-schedule request and subkey stream signals between the DES key store and the round engine.
interface des_ks_if #(
    parameter int NUM_KEYS = 3,
    parameter int SEL_W    = 2
);
    logic [64*NUM_KEYS-1:0] key_in;
    logic [SEL_W-1:0]       key_sel;
    logic                   decrypt;
    logic                   start;
    logic                   subkey_ready;
    logic [47:0]            subkey;
    logic                   subkey_valid;
    logic [3:0]             round;
    logic                   busy;
    logic                   done;
    logic                   sel_err;

    modport master (
        output key_in, key_sel, decrypt, start, subkey_ready,
        input  subkey, subkey_valid, round, busy, done, sel_err
    );

    modport slave (
        input  key_in, key_sel, decrypt, start, subkey_ready,
        output subkey, subkey_valid, round, busy, done, sel_err
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 of a selected key, then sixteen PC-2 subkeys streamed
// one per handshake in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule #(
    parameter int NUM_KEYS = 3,
    parameter int SEL_W    = 2
) (
    input  logic       clk,
    input  logic       rst,
    des_ks_if.slave    ks,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
        return r;
    endfunction

    // Encrypt rotates left, decrypt undoes the same schedule by rotating right.
    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic dec, input logic one);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (!dec && one) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end else if (!dec) begin
            c = {c[25:0], c[27:26]};
            d = {d[25:0], d[27:26]};
        end else if (one) begin
            c = {c[0], c[27:1]};
            d = {d[0], d[27:1]};
        end else begin
            c = {c[1:0], c[27:2]};
            d = {d[1:0], d[27:2]};
        end
        return {c, d};
    endfunction

    state_t      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic        dec_q, dec_d;
    logic [3:0]  round_q, round_d;
    logic [47:0] subkey_q, subkey_d;
    logic        sel_err_q, sel_err_d;

    logic [63:0] sel_key;
    logic [55:0] pc1_out;
    logic [3:0]  nxt_round;
    logic        one_step;
    logic        sel_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cd_q      <= '0;
            dec_q     <= 1'b0;
            round_q   <= '0;
            subkey_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cd_q      <= cd_d;
            dec_q     <= dec_d;
            round_q   <= round_d;
            subkey_q  <= subkey_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Handshake: a subkey transfers on a rising edge where subkey_valid and subkey_ready are both high;
    // while ready is low the subkey, round and C/D hold, and valid never drops mid-run.
    always_comb begin
        state_d   = state_q;
        cd_d      = cd_q;
        dec_d     = dec_q;
        round_d   = round_q;
        subkey_d  = subkey_q;
        sel_err_d = 1'b0;
        sel_key   = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (ks.key_sel == SEL_W'(k)) sel_key = ks.key_in[64*k +: 64];
        end
        sel_ok    = int'(ks.key_sel) < NUM_KEYS;
        pc1_out   = pc1(sel_key);
        nxt_round = round_q + 4'd1;
        one_step  = (nxt_round == 4'd1) || (nxt_round == 4'd8) || (nxt_round == 4'd15);

        case (state_q)
            S_RUN: begin
                if (ks.subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = S_FIN;
                    end else begin
                        cd_d     = rot_cd(cd_q, dec_q, one_step);
                        round_d  = nxt_round;
                        subkey_d = pc2(cd_d);
                    end
                end
            end
            default: begin
                // FIN lasts one cycle and behaves like IDLE for a new start.
                if (state_q == S_FIN) state_d = S_IDLE;
                if (ks.start) begin
                    if (sel_ok) begin
                        state_d  = S_RUN;
                        dec_d    = ks.decrypt;
                        round_d  = '0;
                        cd_d     = ks.decrypt ? pc1_out : rot_cd(pc1_out, 1'b0, 1'b1);
                        subkey_d = pc2(cd_d);
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign ks.subkey       = subkey_q;
    assign ks.subkey_valid = (state_q == S_RUN);
    assign ks.round        = round_q;
    assign ks.busy         = (state_q != S_IDLE);
    assign ks.done         = (state_q == S_FIN);
    assign ks.sel_err      = sel_err_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: behavioural DES key-schedule model feeding an expected queue,
// with a negedge monitor popping and comparing every accepted subkey.
module tb_des_key_schedule;
    localparam int NK = 3;

    logic clk;
    logic rst;
    logic [1:0] dut_state;

    des_ks_if #(.NUM_KEYS(NK), .SEL_W(2)) ifc ();

    des_key_schedule #(.NUM_KEYS(NK), .SEL_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .ks      (ifc.slave),
        .state_o (dut_state)
    );

    int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    bit rnd_ready = 0;

    logic [51:0] exp_q[$];
    logic [47:0] model_k [16];
    logic [47:0] cap [16];
    logic [47:0] cap_save [16];
    logic [63:0] keys [NK];

    // clock / reset
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // consumer ready: always high, or random when rnd_ready is set
    initial begin
        ifc.subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifc.subkey_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Software DES key schedule: cumulative left rotation of C0/D0, reversed for decrypt.
    task automatic model(input logic [63:0] key, input bit dec);
        bit kb [1:64];
        bit c [28];
        bit d [28];
        int tot;
        int p;
        logic [47:0] k;
        for (int n = 1; n <= 64; n++) kb[n] = key[64-n];
        for (int i = 0; i < 28; i++) begin
            c[i] = kb[PC1[i]];
            d[i] = kb[PC1[i+28]];
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            k = '0;
            for (int j = 0; j < 48; j++) begin
                p = PC2[j];
                if (p <= 28) k[47-j] = c[(p - 1 + tot) % 28];
                else         k[47-j] = d[(p - 29 + tot) % 28];
            end
            model_k[dec ? 15 - r : r] = k;
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [52:0] held;
        logic [51:0] e;
        bit held_v;
        held_v = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0;
            end else begin
                if (held_v) begin
                    checks++;
                    if ({ifc.subkey_valid, ifc.round, ifc.subkey} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b r=%0d k=%h, held r=%0d k=%h",
                                 ifc.subkey_valid, ifc.round, ifc.subkey, held[51:48], held[47:0]);
                    end
                end
                held_v = 0;
                if (ifc.subkey_valid) begin
                    if (ifc.subkey_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_subkey: got r=%0d k=%h, expected none", ifc.round, ifc.subkey);
                        end else begin
                            e = exp_q.pop_front();
                            if ({ifc.round, ifc.subkey} !== e) begin
                                errors++;
                                $display("FAIL subkey: got r=%0d k=%h, expected r=%0d k=%h",
                                         ifc.round, ifc.subkey, e[51:48], e[47:0]);
                            end
                        end
                        cap[ifc.round] = ifc.subkey;
                        acc_cnt++;
                    end else begin
                        held_v = 1;
                        held = {1'b1, ifc.round, ifc.subkey};
                    end
                end
                if (ifc.done) done_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic drive_keys();
        ifc.key_in = {keys[2], keys[1], keys[0]};
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic do_run(input int sel, input bit dec, input bit rnd, input bit disturb);
        int cyc;
        int acc0;
        int done0;
        model(keys[sel], dec);
        for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), model_k[r]});
        acc0 = acc_cnt;
        done0 = done_cnt;
        rnd_ready = rnd;
        drive_keys();
        ifc.key_sel = 2'(sel);
        ifc.decrypt = dec;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        cyc = 0;
        while (!ifc.done && cyc < 600) begin
            if (disturb && cyc == 4) begin
                ifc.start = 1'b1;
                ifc.key_sel = 2'((sel + 1) % NK);
                ifc.decrypt = !dec;
                ifc.key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end else if (disturb && cyc == 5) begin
                ifc.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (!ifc.done) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        end
        if (!rnd) check("done_latency", 64'(cyc), 64'd16);
        @(posedge clk);
        #1;
        check("idle_after_done", {62'd0, ifc.busy, ifc.done}, 64'd0);
        check("done_count", 64'(done_cnt - done0), 64'd1);
        check("accept_count", 64'(acc_cnt - acc0), 64'd16);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        rnd_ready = 0;
        ifc.decrypt = 1'b0;
        ifc.key_sel = '0;
        drive_keys();
    endtask

    task automatic check_zero(input string name);
        check(name, {ifc.subkey, ifc.subkey_valid, ifc.round, ifc.busy, ifc.done, ifc.sel_err}, 64'd0);
    endtask

    initial begin
        int cyc;
        int done0;
        logic [63:0] kat0;
        logic [63:0] kat15;
        keys[0] = 64'h133457799BBCDFF1;
        keys[1] = 64'h3B3898371520F75E;
        keys[2] = 64'h1234567890ABCDEF;
        drive_keys();
        ifc.key_sel = '0;
        ifc.decrypt = 1'b0;
        ifc.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // known-answer runs on slot 0
        do_run(0, 0, 0, 0);
        kat0 = 64'(cap[0]);
        kat15 = 64'(cap[15]);
        check("kat_enc_k1", kat0, 64'h1B02EFFC7072);
        check("kat_enc_k16", kat15, 64'hCB3D8B0E17F5);
        do_run(0, 1, 0, 0);
        kat0 = 64'(cap[0]);
        kat15 = 64'(cap[15]);
        check("kat_dec_r0", kat0, 64'hCB3D8B0E17F5);
        check("kat_dec_r15", kat15, 64'h1B02EFFC7072);

        do_run(1, 0, 0, 0);
        do_run(2, 1, 0, 0);
        do_run(2, 0, 1, 0);

        // parity bits must not affect the subkeys
        cap_save = cap;
        keys[2] = keys[2] ^ 64'h0101010101010101;
        do_run(2, 0, 0, 0);
        checks++;
        if (cap != cap_save) begin
            errors++;
            $display("FAIL parity_ignored: got k1=%h, expected k1=%h", cap[0], cap_save[0]);
        end
        keys[2] = 64'h1234567890ABCDEF;

        // start and key changes mid-run are ignored
        do_run(1, 1, 0, 1);

        // out-of-range key select
        ifc.key_sel = 2'd3;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.key_sel = '0;
        check("sel_err_pulse", {62'd0, ifc.sel_err, ifc.busy}, 64'd2);
        @(posedge clk);
        #1;
        check("sel_err_clear", {61'd0, ifc.sel_err, ifc.busy, ifc.subkey_valid}, 64'd0);

        // reset at round 7 aborts the run without done
        model(keys[0], 0);
        for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), model_k[r]});
        done0 = done_cnt;
        ifc.key_sel = '0;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        cyc = 0;
        while (!(ifc.subkey_valid && ifc.round == 4'd7) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach_round7", 64'(ifc.round), 64'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrun_reset_outputs");
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("no_done_on_abort", 64'(done_cnt - done0), 64'd0);
        do_run(0, 1, 0, 0);

        // randomized keys, slots, direction and consumer backpressure
        for (int t = 0; t < 8; t++) begin
            for (int s = 0; s < NK; s++) keys[s] = {$urandom, $urandom};
            do_run($urandom_range(0, NK - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
